bpu: RTL and testbench

Branch prediction unit for the LoongArch 32-bit pipeline. It holds a direct-mapped branch target buffer with 2-bit saturating counters. In IF it produces `Pre_Branch`/`Pre_PC` for the next-PC select from the current fetch PC. In EX it resolves each branch against the prediction carried down the pipe and produces the redirect that takes priority at next-PC select. It then trains the table.

---
 rtl/bpu_pkg.sv | 20 ++
 rtl/bpu_ctr2.sv | 23 ++
 rtl/bpu.sv | 125 ++++++++++++
 tb/tb_bpu.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: word width and the
// 2-bit saturating counter encodings used by every table entry.
package bpu_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Counter value held by every entry coming out of reset.
  localparam ctr_t CTR_RST = WNT;

  // Counter value given to a freshly allocated entry (first seen taken).
  localparam ctr_t CTR_ALLOC = WT;

endpackage : bpu_pkg

// File: rtl/bpu_ctr2.sv
// 2-bit saturating counter next-state function: counts up on taken,
// down on not-taken, and sticks at ST / SNT.
module bpu_ctr2
  import bpu_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  // Saturating increment/decrement of the direction counter.
  always_comb begin
    ctr_next = ctr;
    case (ctr)
      SNT: ctr_next = taken ? WNT : SNT;
      WNT: ctr_next = taken ? WT  : SNT;
      WT:  ctr_next = taken ? ST  : WNT;
      ST:  ctr_next = taken ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule : bpu_ctr2

// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit counters.
// IF side: combinational lookup producing Pre_Branch / Pre_PC.
// EX side: combinational resolve producing the redirect, then training
// of the table on the clock edge.
// There is no handshake: EX_Valid qualifies every EX input for exactly one
// cycle, and the block accepts one resolve per cycle with no back-pressure.
module bpu
  import bpu_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] IF_PC,
  output logic            Pre_Branch,
  output logic [WORD-1:0] Pre_PC,
  input  logic            EX_Valid,
  input  logic            EX_Is_Branch,
  input  logic            EX_Taken,
  input  logic [WORD-1:0] EX_Inst_PC,
  input  logic [WORD-1:0] EX_Target,
  input  logic            EX_Pred_Taken,
  input  logic [WORD-1:0] EX_Pred_PC,
  output logic            EX_Branch,
  output logic [WORD-1:0] EX_PC,
  output logic [15:0]     Br_Count,
  output logic [15:0]     Miss_Count
);

  localparam int ENTRIES = 1 << IDX_W;

  // Table held in flops so the lookup stays asynchronous.
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [WORD-1:0]  tgt_q   [ENTRIES];
  ctr_t             ctr_q   [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_act_taken;
  logic [WORD-1:0]  ex_seq_pc;
  logic [WORD-1:0]  ex_act_pc;
  ctr_t             ex_ctr_next;

  assign if_idx = IF_PC[IDX_W+1:2];
  assign if_tag = IF_PC[WORD-1:IDX_W+2];
  assign ex_idx = EX_Inst_PC[IDX_W+1:2];
  assign ex_tag = EX_Inst_PC[WORD-1:IDX_W+2];

  // Fetch-side lookup: predict taken only on a tag hit with a taken-leaning counter.
  always_comb begin
    if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    Pre_Branch = if_hit && ctr_q[if_idx][1];
    Pre_PC     = Pre_Branch ? tgt_q[if_idx] : IF_PC + 32'd4;
  end

  // EX-side resolve: compare the piped prediction with the real outcome.
  // A non-branch counts as not-taken, which flushes aliased predictions.
  always_comb begin
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_act_taken = EX_Is_Branch && EX_Taken;
    ex_seq_pc    = EX_Inst_PC + 32'd4;
    ex_act_pc    = ex_act_taken ? EX_Target : ex_seq_pc;
    EX_Branch    = EX_Valid &&
                   ((EX_Pred_Taken != ex_act_taken) ||
                    (EX_Pred_Taken && ex_act_taken && (EX_Pred_PC != EX_Target)));
    EX_PC        = EX_Branch ? ex_act_pc : ex_seq_pc;
  end

  bpu_ctr2 u_ctr2 (
    .ctr      (ctr_q[ex_idx]),
    .taken    (EX_Taken),
    .ctr_next (ex_ctr_next)
  );

  // Table training: update on hit, allocate on taken miss, drop aliased non-branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RST;
      end
    end else if (EX_Valid) begin
      if (EX_Is_Branch) begin
        if (ex_hit) begin
          ctr_q[ex_idx] <= ex_ctr_next;
          if (EX_Taken) begin
            tgt_q[ex_idx] <= EX_Target;
          end
        end else if (EX_Taken) begin
          valid_q[ex_idx] <= 1'b1;
          tag_q[ex_idx]   <= ex_tag;
          tgt_q[ex_idx]   <= EX_Target;
          ctr_q[ex_idx]   <= CTR_ALLOC;
        end
      end else if (ex_hit) begin
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

  // Wrapping statistics: resolved branches and issued redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Br_Count   <= '0;
      Miss_Count <= '0;
    end else begin
      if (EX_Valid && EX_Is_Branch) begin
        Br_Count <= Br_Count + 16'd1;
      end
      if (EX_Branch) begin
        Miss_Count <= Miss_Count + 16'd1;
      end
    end
  end

endmodule : bpu

// File: tb/tb_bpu.sv
// Self-checking bench for bpu: directed scenarios from the feature list plus
// a randomized run against a behavioural table model.
module tb_bpu;

  localparam int NENT = 16;
  localparam int SBW  = 66;

  logic        clk;
  logic        rst;
  logic [31:0] IF_PC;
  logic        Pre_Branch;
  logic [31:0] Pre_PC;
  logic        EX_Valid;
  logic        EX_Is_Branch;
  logic        EX_Taken;
  logic [31:0] EX_Inst_PC;
  logic [31:0] EX_Target;
  logic        EX_Pred_Taken;
  logic [31:0] EX_Pred_PC;
  logic        EX_Branch;
  logic [31:0] EX_PC;
  logic [15:0] Br_Count;
  logic [15:0] Miss_Count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  bit          m_valid [NENT];
  logic [31:0] m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  int          m_br;
  int          m_miss;

  logic [SBW-1:0] exp_q[$];

  bpu dut (
    .clk           (clk),
    .rst           (rst),
    .IF_PC         (IF_PC),
    .Pre_Branch    (Pre_Branch),
    .Pre_PC        (Pre_PC),
    .EX_Valid      (EX_Valid),
    .EX_Is_Branch  (EX_Is_Branch),
    .EX_Taken      (EX_Taken),
    .EX_Inst_PC    (EX_Inst_PC),
    .EX_Target     (EX_Target),
    .EX_Pred_Taken (EX_Pred_Taken),
    .EX_Pred_PC    (EX_Pred_PC),
    .EX_Branch     (EX_Branch),
    .EX_PC         (EX_PC),
    .Br_Count      (Br_Count),
    .Miss_Count    (Miss_Count)
  );

  // Clock / reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic void m_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
    m_br   = 0;
    m_miss = 0;
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic pb, output logic [31:0] ppc);
    int i;
    i   = m_idx(pc);
    pb  = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    ppc = pb ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_resolve(output logic br, output logic [31:0] npc);
    logic act;
    logic [31:0] nxt;
    act = EX_Is_Branch && EX_Taken;
    nxt = act ? EX_Target : EX_Inst_PC + 32'd4;
    br  = EX_Valid && ((EX_Pred_Taken != act) || (EX_Pred_Taken && act && (EX_Pred_PC != EX_Target)));
    npc = br ? nxt : EX_Inst_PC + 32'd4;
  endfunction

  // Applies the effect of one clock edge given the inputs currently driven.
  function automatic void m_edge();
    int i;
    bit hit;
    logic br;
    logic [31:0] npc;
    if (rst) begin
      m_reset();
      return;
    end
    m_resolve(br, npc);
    if (br) m_miss = (m_miss + 1) % 65536;
    if (!EX_Valid) return;
    i   = m_idx(EX_Inst_PC);
    hit = m_valid[i] && (m_tag[i] == m_tagof(EX_Inst_PC));
    if (EX_Is_Branch) begin
      m_br = (m_br + 1) % 65536;
      if (hit) begin
        if (EX_Taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = EX_Target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (EX_Taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(EX_Inst_PC);
        m_tgt[i]   = EX_Target;
        m_ctr[i]   = 2;
      end
    end else if (hit) begin
      m_valid[i] = 1'b0;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic isb, input logic tk, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ppc);
    EX_Valid      = v;
    EX_Is_Branch  = isb;
    EX_Taken      = tk;
    EX_Inst_PC    = pc;
    EX_Target     = tgt;
    EX_Pred_Taken = pt;
    EX_Pred_PC    = ppc;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // One resolve of a branch at pc, with prediction taken from the model lookup.
  task automatic resolve_pred(input logic isb, input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
    logic pb;
    logic [31:0] ppc;
    m_lookup(pc, pb, ppc);
    drive_ex(1'b1, isb, tk, pc, tgt, pb, ppc);
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_ex();
    IF_PC = 32'h1C000010;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (Pre_Branch !== 1'b0 || Pre_PC !== 32'h1C000014) begin
      errors++;
      $display("FAIL reset_lookup: got pb=%0b pc=%h want pb=0 pc=1c000014", Pre_Branch, Pre_PC);
    end
    checks++;
    if (Br_Count !== 16'd0 || Miss_Count !== 16'd0 || EX_Branch !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: got br=%0d miss=%0d exb=%0b want 0 0 0", Br_Count, Miss_Count, EX_Branch);
    end
  endtask

  task automatic test_first_taken();
    drive_ex(1'b1, 1'b1, 1'b1, 32'h1C000010, 32'h1C000100, 1'b0, 32'h1C000014);
    #1;
    checks++;
    if (EX_Branch !== 1'b1 || EX_PC !== 32'h1C000100) begin
      errors++;
      $display("FAIL first_redirect: got exb=%0b pc=%h want 1 1c000100", EX_Branch, EX_PC);
    end
    step();
    idle_ex();
    IF_PC = 32'h1C000010;
    #1;
    checks++;
    if (Miss_Count !== 16'd1 || Br_Count !== 16'd1) begin
      errors++;
      $display("FAIL first_counts: got miss=%0d br=%0d want 1 1", Miss_Count, Br_Count);
    end
    checks++;
    if (Pre_Branch !== 1'b1 || Pre_PC !== 32'h1C000100) begin
      errors++;
      $display("FAIL first_predict: got pb=%0b pc=%h want 1 1c000100", Pre_Branch, Pre_PC);
    end
  endtask

  task automatic test_saturation();
    IF_PC = 32'h1C000010;
    repeat (3) resolve_pred(1'b1, 1'b1, 32'h1C000010, 32'h1C000100);
    // From ST, one not-taken must still predict taken.
    resolve_pred(1'b1, 1'b0, 32'h1C000010, 32'h0);
    idle_ex();
    #1;
    checks++;
    if (Pre_Branch !== 1'b1) begin
      errors++;
      $display("FAIL sat_high: got pb=%0b want 1", Pre_Branch);
    end
    resolve_pred(1'b1, 1'b0, 32'h1C000010, 32'h0);
    idle_ex();
    #1;
    checks++;
    if (Pre_Branch !== 1'b0 || Pre_PC !== 32'h1C000014) begin
      errors++;
      $display("FAIL sat_two_nt: got pb=%0b pc=%h want 0 1c000014", Pre_Branch, Pre_PC);
    end
    repeat (3) resolve_pred(1'b1, 1'b0, 32'h1C000010, 32'h0);
    // Held at SNT: one taken reaches WNT, still not-taken.
    resolve_pred(1'b1, 1'b1, 32'h1C000010, 32'h1C000100);
    idle_ex();
    #1;
    checks++;
    if (Pre_Branch !== 1'b0) begin
      errors++;
      $display("FAIL sat_low_hold: got pb=%0b want 0", Pre_Branch);
    end
    resolve_pred(1'b1, 1'b1, 32'h1C000010, 32'h1C000100);
    idle_ex();
    #1;
    checks++;
    if (Pre_Branch !== 1'b1 || Pre_PC !== 32'h1C000100) begin
      errors++;
      $display("FAIL sat_recover: got pb=%0b pc=%h want 1 1c000100", Pre_Branch, Pre_PC);
    end
  endtask

  task automatic test_alias();
    logic pb;
    logic [31:0] ppc;
    drive_ex(1'b1, 1'b0, 1'b0, 32'h1C000050, 32'h0, 1'b1, 32'h1C000100);
    #1;
    checks++;
    if (EX_Branch !== 1'b1 || EX_PC !== 32'h1C000054) begin
      errors++;
      $display("FAIL alias_redirect: got exb=%0b pc=%h want 1 1c000054", EX_Branch, EX_PC);
    end
    step();
    idle_ex();
    IF_PC = 32'h1C000050;
    #1;
    checks++;
    if (Pre_Branch !== 1'b0 || Pre_PC !== 32'h1C000054) begin
      errors++;
      $display("FAIL alias_other_pc: got pb=%0b pc=%h want 0 1c000054", Pre_Branch, Pre_PC);
    end
    // Non-branch hitting its own entry invalidates it.
    drive_ex(1'b1, 1'b0, 1'b0, 32'h1C000010, 32'h0, 1'b1, 32'h1C000100);
    step();
    idle_ex();
    IF_PC = 32'h1C000010;
    #1;
    m_lookup(IF_PC, pb, ppc);
    checks++;
    if (Pre_Branch !== 1'b0 || Pre_PC !== 32'h1C000014 || Pre_Branch !== pb) begin
      errors++;
      $display("FAIL alias_invalidate: got pb=%0b pc=%h want 0 1c000014", Pre_Branch, Pre_PC);
    end
  endtask

  task automatic test_wrong_target();
    drive_ex(1'b1, 1'b1, 1'b1, 32'h00000020, 32'h00000100, 1'b0, 32'h00000024);
    step();
    drive_ex(1'b1, 1'b1, 1'b1, 32'h00000020, 32'h00000200, 1'b1, 32'h00000100);
    #1;
    checks++;
    if (EX_Branch !== 1'b1 || EX_PC !== 32'h00000200) begin
      errors++;
      $display("FAIL wrong_target_redirect: got exb=%0b pc=%h want 1 00000200", EX_Branch, EX_PC);
    end
    step();
    idle_ex();
    IF_PC = 32'h00000020;
    #1;
    checks++;
    if (Pre_Branch !== 1'b1 || Pre_PC !== 32'h00000200) begin
      errors++;
      $display("FAIL wrong_target_lookup: got pb=%0b pc=%h want 1 00000200", Pre_Branch, Pre_PC);
    end
  endtask

  task automatic test_same_index();
    // Entry at 0x1C000030 allocated (WT); then a not-taken while looking it up.
    drive_ex(1'b1, 1'b1, 1'b1, 32'h1C000030, 32'h1C000300, 1'b0, 32'h1C000034);
    step();
    IF_PC = 32'h1C000030;
    drive_ex(1'b1, 1'b1, 1'b0, 32'h1C000030, 32'h0, 1'b1, 32'h1C000300);
    #1;
    checks++;
    if (Pre_Branch !== 1'b1 || Pre_PC !== 32'h1C000300) begin
      errors++;
      $display("FAIL same_index_old: got pb=%0b pc=%h want 1 1c000300", Pre_Branch, Pre_PC);
    end
    step();
    idle_ex();
    #1;
    checks++;
    if (Pre_Branch !== 1'b0 || Pre_PC !== 32'h1C000034) begin
      errors++;
      $display("FAIL same_index_new: got pb=%0b pc=%h want 0 1c000034", Pre_Branch, Pre_PC);
    end
  endtask

  task automatic test_stall();
    logic [15:0] br0;
    logic [15:0] ms0;
    br0 = Br_Count;
    ms0 = Miss_Count;
    drive_ex(1'b0, 1'b1, 1'b1, 32'h1C000040, 32'h1C000400, 1'b0, 32'h0);
    #1;
    checks++;
    if (EX_Branch !== 1'b0 || EX_PC !== 32'h1C000044) begin
      errors++;
      $display("FAIL stall_redirect: got exb=%0b pc=%h want 0 1c000044", EX_Branch, EX_PC);
    end
    step();
    IF_PC = 32'h1C000040;
    #1;
    checks++;
    if (Pre_Branch !== 1'b0 || Br_Count !== br0 || Miss_Count !== ms0) begin
      errors++;
      $display("FAIL stall_no_update: got pb=%0b br=%0d miss=%0d want 0 %0d %0d",
               Pre_Branch, Br_Count, Miss_Count, br0, ms0);
    end
    idle_ex();
  endtask

  task automatic test_reset_mid();
    drive_ex(1'b1, 1'b1, 1'b1, 32'h1C000060, 32'h1C000600, 1'b0, 32'h1C000064);
    step();
    IF_PC = 32'h1C000060;
    // Pending taken update still driven while reset hits between edges.
    drive_ex(1'b1, 1'b1, 1'b1, 32'h1C000060, 32'h1C000700, 1'b0, 32'h1C000064);
    #1;
    checks++;
    if (Pre_Branch !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_before: got pb=%0b want 1", Pre_Branch);
    end
    rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if (Pre_Branch !== 1'b0 || Pre_PC !== 32'h1C000064 || Br_Count !== 16'd0 || Miss_Count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got pb=%0b pc=%h br=%0d miss=%0d want 0 1c000064 0 0",
               Pre_Branch, Pre_PC, Br_Count, Miss_Count);
    end
    checks++;
    if (EX_Branch !== 1'b1 || EX_PC !== 32'h1C000700) begin
      errors++;
      $display("FAIL reset_mid_exbranch: got exb=%0b pc=%h want 1 1c000700", EX_Branch, EX_PC);
    end
    step();
    rst = 1'b0;
    idle_ex();
    #1;
  endtask

  task automatic test_random();
    logic pb;
    logic [31:0] ppc;
    logic br;
    logic [31:0] npc;
    logic [SBW-1:0] got;
    logic [SBW-1:0] exp;
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      pc = 32'h1C000000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      m_lookup(pc, pb, ppc);
      if ($urandom_range(0, 7) == 0) begin
        pb  = 1'($urandom_range(0, 1));
        ppc = 32'h1C000000 | (32'($urandom_range(0, 7)) << 4);
      end
      drive_ex(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               pc, 32'h1C000000 | (32'($urandom_range(0, 7)) << 4), pb, ppc);
      IF_PC = 32'h1C000000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      m_lookup(IF_PC, pb, ppc);
      m_resolve(br, npc);
      exp_q.push_back({pb, ppc, br, npc});
      #1;
      got = {Pre_Branch, Pre_PC, EX_Branch, EX_PC};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_outputs[%0d]: got pb=%0b ppc=%h exb=%0b expc=%h want pb=%0b ppc=%h exb=%0b expc=%h",
                 n, got[65], got[64:33], got[32], got[31:0], exp[65], exp[64:33], exp[32], exp[31:0]);
      end
      step();
      checks++;
      if (Br_Count !== 16'(m_br) || Miss_Count !== 16'(m_miss)) begin
        errors++;
        $display("FAIL random_counts[%0d]: got br=%0d miss=%0d want %0d %0d", n, Br_Count, Miss_Count, m_br, m_miss);
      end
    end
    idle_ex();
  endtask

  task automatic test_counter_wrap();
    // Every cycle is a branch resolve that mispredicts, so both counters wrap.
    drive_ex(1'b1, 1'b1, 1'b1, 32'h1C000080, 32'h1C000800, 1'b0, 32'h1C000084);
    for (int n = 0; n < 65540; n++) begin
      step();
    end
    idle_ex();
    #1;
    checks++;
    if (Br_Count !== 16'(m_br) || Miss_Count !== 16'(m_miss)) begin
      errors++;
      $display("FAIL counter_wrap: got br=%0d miss=%0d want %0d %0d", Br_Count, Miss_Count, m_br, m_miss);
    end
  endtask

  initial begin
    rst = 1'b0;
    IF_PC = 32'h0;
    idle_ex();
    test_reset();
    test_first_taken();
    test_saturation();
    test_alias();
    test_wrong_target();
    test_same_index();
    test_stall();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bpu
